keypad_debouncer: RTL

Front-end conditioning stage for the calculator keypad, sitting directly upstream of the opcode encoder. It synchronizes raw, bouncing button levels from the pads and debounces them with a press/release state machine. Each clean press produces exactly one single-cycle one-hot strobe that feeds the encoder's 3-bit key input. Simultaneous multi-key presses are rejected and flagged.

---
 rtl/keypad_debouncer_if.sv | 28 ++
 rtl/keypad_debouncer.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/keypad_debouncer_if.sv
// Keypad debouncer signal bundle: raw button levels in, press strobes,
// the held-key level and the multi-key error flag out.
interface keypad_debouncer_if #(
  parameter int N_KEYS = 3
);

  logic [N_KEYS-1:0] btn_raw;    // raw pad levels, asynchronous, active-high
  logic [N_KEYS-1:0] key_out;    // one-hot, one-cycle press strobe
  logic [N_KEYS-1:0] key_held;   // one-hot level of the accepted key
  logic              multi_err;  // one-cycle pulse on a rejected multi-key press

  // Stimulus / consumer side
  modport master (
    output btn_raw,
    input  key_out,
    input  key_held,
    input  multi_err
  );

  // Debouncer side
  modport slave (
    input  btn_raw,
    output key_out,
    output key_held,
    output multi_err
  );

endinterface

// File: rtl/keypad_debouncer.sv
// Keypad front end: two-flop synchronizer followed by a press/release
// debounce state machine. A clean single-key press yields exactly one
// one-hot strobe; a stable multi-key pattern is rejected with a pulse on
// multi_err. After any accepted or rejected press the block waits for a
// fully debounced release before it will look at the keys again.
module keypad_debouncer #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              nrst,
  keypad_debouncer_if.slave bus
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  // The sample that captures a candidate is itself the first matching
  // sample of the press window, so PRESS_WAIT only needs
  // DEBOUNCE_CYCLES-1 further matches; the last of them arrives with
  // cnt == DEBOUNCE_CYCLES-2. The release window starts after the first
  // zero sample, so it runs the full DEBOUNCE_CYCLES samples.
  localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
  localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  logic [N_KEYS-1:0] s1_q;
  logic [N_KEYS-1:0] btn_sync_q;

  state_t            state_q,     state_d;
  logic [N_KEYS-1:0] cand_q,      cand_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic              valid_q,     valid_d;
  logic [N_KEYS-1:0] key_out_q,   key_out_d;
  logic              multi_err_q, multi_err_d;

  // Exactly one bit set.
  function automatic logic is_onehot(input logic [N_KEYS-1:0] v);
    return (v != '0) && ((v & (v - N_KEYS'(1))) == '0);
  endfunction

  // Bring the asynchronous pad levels into the clk domain.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      s1_q       <= '0;
      btn_sync_q <= '0;
    end else begin
      s1_q       <= bus.btn_raw;
      btn_sync_q <= s1_q;
    end
  end

  // Debounce state, candidate, counter and registered output pulses.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= IDLE;
      cand_q      <= '0;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      key_out_q   <= '0;
      multi_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      valid_q     <= valid_d;
      key_out_q   <= key_out_d;
      multi_err_q <= multi_err_d;
    end
  end

  // Next-state logic: press window, accept/reject, hold, release window.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    valid_d     = valid_q;
    key_out_d   = '0;
    multi_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (btn_sync_q != '0) begin
          cand_d  = btn_sync_q;
          cnt_d   = '0;
          state_d = PRESS_WAIT;
        end
      end

      PRESS_WAIT: begin
        if (btn_sync_q == '0) begin
          // Bounced back open before the window completed.
          cnt_d   = '0;
          state_d = IDLE;
        end else if (btn_sync_q != cand_q) begin
          // Pattern changed: the new pattern starts its own window.
          cand_d = btn_sync_q;
          cnt_d  = '0;
        end else if (cnt_q == PRESS_LAST) begin
          cnt_d   = '0;
          state_d = HELD;
          if (is_onehot(cand_q)) begin
            key_out_d = cand_q;
            valid_d   = 1'b1;
          end else begin
            multi_err_d = 1'b1;
            valid_d     = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      HELD: begin
        // Extra or swapped keys are ignored until everything is released.
        if (btn_sync_q == '0) begin
          cnt_d   = '0;
          state_d = RELEASE_WAIT;
        end
      end

      RELEASE_WAIT: begin
        if (btn_sync_q != '0) begin
          // Release bounce: back to HELD, no new strobe.
          cnt_d   = '0;
          state_d = HELD;
        end else if (cnt_q == RELEASE_LAST) begin
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        cnt_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.key_out   = key_out_q;
  assign bus.multi_err = multi_err_q;
  assign bus.key_held  = (valid_q && (state_q == HELD || state_q == RELEASE_WAIT))
                         ? cand_q : '0;

endmodule
